sha256_message_scheduler: RTL and testbench
===========================================

Name: sha256_message_scheduler

Overview:
- Producer side of the W-word interface into the SHA-256 round engine.
- Accepts one 512-bit padded message block and expands it into the 64-entry message schedule W[0..63].
- Streams one word per transfer over a valid/ready handshake, tagged with the round index.
- Optionally also supplies the matching round constant K[t], so the round engine consumes W and K from a single source.

Parameters:
- NUM_ROUNDS, 64, schedule length; fixed at 64 for SHA-256 and not to be overridden.
- WORD_W, 32, word width; fixed at 32.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  load request; sampled only in IDLE.
- block_in  input  512  padded block; word 0 = block_in[511:480], word 15 = block_in[31:0].
- busy  output  1  high in RUN.
- w_valid  output  1  w_out/round_out/k_out are valid.
- w_ready  input  1  consumer accepts the current word.
- w_out  output  32  W[t].
- round_out  output  6  t, 0..63.
- k_out  output  32  K[t] (see Optional Feature).
- done  output  1  one-cycle pulse after W[63] is transferred.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all 16 window registers=0; counter=0; busy=0, w_valid=0, w_out=0, round_out=0, k_out=0, done=0. Takes effect immediately, including mid-block; the partial schedule is discarded.
- Storage: 16x32 shift window win[0..15], with win[i]=W[t+i]. w_out=win[0]. round_out=counter t.
- States:
  - IDLE: busy=0, w_valid=0. If start=1 at a clock edge: win[i] <= block_in word i; t <= 0; go to RUN. w_valid is high the next cycle, so latency is start -> first valid word = 1 cycle.
  - RUN: busy=1, w_valid=1. A transfer occurs on an edge with w_valid && w_ready. On transfer:
    - shift win[i] <= win[i+1] for i=0..14;
    - win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2^32 (gives W[t+16]);
    - t <= t+1.
    - If t==63 on the transfer: go to IDLE and assert done=1 for exactly the next cycle.
  - done is a registered pulse; it coincides with the first IDLE cycle.
- Small sigmas:
  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - All additions are 32-bit and wrap; carries are dropped.
- Back-pressure: while w_valid=1 and w_ready=0, w_out, round_out and k_out hold stable; no shift occurs.
- w_ready while w_valid=0 is ignored.
- start while in RUN is ignored, and block_in is not resampled.
- start in the cycle done is high (IDLE) is accepted; back-to-back blocks lose only the one IDLE cycle.
- Words generated beyond W[63] (the window refill during the last 16 transfers) are computed but never emitted. The window is left as-is in IDLE.
- The block contains no chaining state; H handling belongs to the round engine.

Optional Feature:
- Macro SHA256_SCHED_K_ROM_EN.
- Defined: an internal 64x32 constant ROM holds the FIPS 180-4 K values. k_out = K[round_out] whenever w_valid=1, combinationally indexed by t, and is stable under back-pressure. k_out = 0 while w_valid=0.
- Undefined: no ROM is built. k_out is tied to 32'h0 at all times, and the consumer takes K from the standalone constant block.

Test Plan:
- "abc" block (block_in = 0x61626380, fourteen zero words, 0x00000018), w_ready=1 -> first valid cycle after start: w_out=0x61626380, round_out=0; W15=0x00000018; W16=0x61626380; W17=0x000F0000. Exactly 64 transfers, then done for 1 cycle; busy falls with it.
- All-zero block -> all 64 words = 0x00000000; done after the 64th transfer.
- Back-pressure: toggle w_ready randomly during "abc" -> the transferred sequence is identical to the w_ready=1 run, and outputs hold while stalled.
- start pulsed at t=10 during RUN with a different block_in -> ignored; the sequence is unchanged; a new block is accepted only once back in IDLE (including the done cycle).
- reset_n low at t=30, asynchronous mid-cycle -> outputs go to reset values immediately; after release, start with "abc" restarts at W0=0x61626380.
- With SHA256_SCHED_K_ROM_EN: k_out=0x428A2F98 at t=0, 0x71374491 at t=1, 0xC67178F2 at t=63. Without the macro: k_out=0 throughout.

Source files
------------

// File: rtl/sha256_message_scheduler.sv
// SHA-256 message schedule generator: expands one 512-bit block into W[0..63] over a valid/ready stream.
// Optional macro SHA256_SCHED_K_ROM_EN adds an internal K[t] ROM driving k_out; otherwise k_out is 0.
module sha256_message_scheduler #(
  parameter int NUM_ROUNDS = 64,
  parameter int WORD_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [511:0]      block_in,
  output logic              busy,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_out,
  output logic [5:0]        round_out,
  output logic [WORD_W-1:0] k_out,
  output logic              done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  t_q;
  logic        done_q;
  logic        load;
  logic        xfer;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign load  = (state_q == S_IDLE) && start;
  assign xfer  = (state_q == S_RUN) && w_ready;
  // win[i] holds W[t+i], so the recurrence taps sit at fixed window positions.
  assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    if (load) begin
      for (int i = 0; i < 16; i++) win_d[i] = block_in[511-32*i -: 32];
    end else if (xfer) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = w_new;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            t_q     <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_ready) begin
            t_q <= t_q + 6'd1;
            if (t_q == 6'(NUM_ROUNDS - 1)) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == S_RUN);
  assign w_valid   = (state_q == S_RUN);
  assign w_out     = win_q[0];
  assign round_out = t_q;
  assign done      = done_q;

`ifdef SHA256_SCHED_K_ROM_EN
  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  // Indexed by the held counter, so K stays aligned with W under back-pressure.
  assign k_out = w_valid ? K_ROM[t_q] : '0;
`else
  assign k_out = '0;
`endif

endmodule

// File: tb/tb_sha256_message_scheduler.sv
// Scoreboard bench: expected W/K per round queued at start, popped by a monitor on each transfer.
module tb_sha256_message_scheduler;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic         w_ready;
  logic         busy, w_valid, done;
  logic [31:0]  w_out, k_out;
  logic [5:0]   round_out;

  sha256_message_scheduler dut (
    .clk(clk), .reset_n(reset_n), .start(start), .block_in(block_in),
    .busy(busy), .w_valid(w_valid), .w_ready(w_ready), .w_out(w_out),
    .round_out(round_out), .k_out(k_out), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  r;
    logic [31:0] w;
    logic [31:0] k;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          xfers = 0;
  bit          ready_rand = 1'b0;
  bit          expect_done = 1'b0;
  logic [31:0] captured [64];
  logic [511:0] abc_blk = {32'h61626380, 448'h0, 32'h00000018};

`ifdef SHA256_SCHED_K_ROM_EN
  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] k_of(input int t);
    return k_tab[t];
  endfunction
`else
  function automatic logic [31:0] k_of(input int t);
    return (t < 0) ? 32'h1 : 32'h0;
  endfunction
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the plain FIPS recurrence over a full 64-entry array.
  task automatic push_block(input logic [511:0] b);
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++) w[i] = ssig1(w[i-2]) + w[i-7] + ssig0(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) begin
      e.r = 6'(i);
      e.w = w[i];
      e.k = k_of(i);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
    return b;
  endfunction

  initial begin
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      w_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares the presented word (stalled or not) against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        expect_done = 1'b0;
      end else begin
        chk("done", {31'b0, done}, {31'b0, expect_done});
        if (expect_done) chk("busy_at_done", {31'b0, busy}, 32'h0);
        expect_done = 1'b0;
        if (w_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got w=%h round=%0d expected no word", w_out, round_out);
          end else begin
            e = exp_q[0];
            chk("w_out", w_out, e.w);
            chk("round_out", {26'b0, round_out}, {26'b0, e.r});
            chk("k_out", k_out, e.k);
            if (w_ready) begin
              void'(exp_q.pop_front());
              captured[e.r] = w_out;
              xfers++;
              if (e.r == 6'd63) expect_done = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic start_block(input logic [511:0] b);
    push_block(b);
    xfers = 0;
    block_in = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("first_valid", {31'b0, w_valid}, 32'h1);
    chk("first_round", {26'b0, round_out}, 32'h0);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", {31'b0, done}, 32'h1);
    chk("xfer_count", 32'(xfers), 32'd64);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_round(input logic [5:0] r);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (w_valid && round_out == r) break;
    end
    chk("reach_round", {26'b0, round_out}, {26'b0, r});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_w_valid"}, {31'b0, w_valid}, 32'h0);
    chk({tag, "_w_out"}, w_out, 32'h0);
    chk({tag, "_round"}, {26'b0, round_out}, 32'h0);
    chk({tag, "_k_out"}, k_out, 32'h0);
    chk({tag, "_done"}, {31'b0, done}, 32'h0);
  endtask

  task automatic chk_abc_points();
    chk("abc_w0", captured[0], 32'h61626380);
    chk("abc_w15", captured[15], 32'h00000018);
    chk("abc_w16", captured[16], 32'h61626380);
    chk("abc_w17", captured[17], 32'h000f0000);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk_zero_outputs("reset");

    @(posedge clk); #1;
    start_block(abc_blk);
    wait_done();
    chk_abc_points();
    $display("abc block, w_ready=1: transfers=%0d", xfers);

    @(posedge clk); #1;
    start_block('0);
    wait_done();
    $display("zero block: transfers=%0d", xfers);

    ready_rand = 1'b1;
    @(posedge clk); #1;
    start_block(abc_blk);
    wait_done();
    chk_abc_points();
    $display("abc block, random w_ready: transfers=%0d", xfers);

    // A start while running must be ignored; a start in the done cycle must be taken.
    @(posedge clk); #1;
    start_block(rand_block());
    wait_round(6'd10);
    block_in = rand_block();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    $display("random block with ignored mid-run start: transfers=%0d", xfers);
    start_block(rand_block());
    wait_done();
    $display("back-to-back block from done cycle: transfers=%0d", xfers);

    @(posedge clk); #1;
    start_block(abc_blk);
    wait_round(6'd30);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("midrun_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    start_block(abc_blk);
    wait_done();
    chk_abc_points();
    $display("abc after mid-run reset: transfers=%0d", xfers);

    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      start_block(rand_block());
      wait_done();
      $display("random block %0d: transfers=%0d", b, xfers);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
